// File: rtl/i2s_stream_scheduler.sv
// i2s_stream_scheduler: streams frame-RAM rows as serial words.
// Each row is a 16-bit header {nx, ny, 2'b00, row} followed by W = (nx+1)*(ny+1)
// payload words, then cfg_gap idle bits. Reads are prefetched two bits ahead so
// the serial stream has no bubbles across header, word and row boundaries.
module i2s_stream_scheduler (
  input  logic        i2s_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  cfg_nx,
  input  logic [3:0]  cfg_ny,
  input  logic [5:0]  cfg_last_row,
  input  logic [3:0]  cfg_gap,
  output logic        rd_en,
  output logic [13:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        i2s_data,
  output logic        busy,
  output logic        row_done,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_q, bit_d;       // bit index in header/word, or gap cycle count
  logic [7:0]  word_q, word_d;     // payload word index within the row
  logic [5:0]  row_q, row_d;
  logic [13:0] base_q, base_d;     // RAM address of word 0 of the current row
  logic [15:0] sr_q, sr_d;         // output shifter, MSB drives i2s_data
  logic [3:0]  nx_q, nx_d, ny_q, ny_d, gap_q, gap_d;
  logic [5:0]  last_q, last_d;
  logic [8:0]  words_q, words_d;   // W, latched once per frame
  logic        rd_en_q, rd_en_d;
  logic [13:0] rd_addr_q, rd_addr_d;
  logic        busy_q, busy_d, row_done_q, row_done_d, frame_done_q, frame_done_d;

  logic        start_frame, next_row;
  logic [8:0]  w_new;
  logic [7:0]  wlast;

  assign w_new = (9'(cfg_nx) + 9'd1) * (9'(cfg_ny) + 9'd1);
  assign wlast = 8'(words_q - 9'd1);

  // Next-state logic; outputs are computed from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    word_d      = word_q;
    row_d       = row_q;
    base_d      = base_q;
    sr_d        = sr_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    gap_d       = gap_q;
    last_d      = last_q;
    words_d     = words_q;
    start_frame = 1'b0;
    next_row    = 1'b0;

    case (state_q)
      IDLE: if (enable) start_frame = 1'b1;
      HEADER: begin
        bit_d = bit_q + 4'd1;
        sr_d  = {sr_q[14:0], 1'b0};
        if (bit_q == 4'd15) begin
          state_d = PAYLOAD;
          bit_d   = 4'd0;
          word_d  = 8'd0;
          sr_d    = rd_data;
        end
      end
      PAYLOAD: begin
        bit_d = bit_q + 4'd1;
        sr_d  = {sr_q[14:0], 1'b0};
        if (bit_q == 4'd15) begin
          if (word_q == wlast) begin
            if (gap_q != 4'd0) begin
              state_d = GAP;
              bit_d   = 4'd0;
              sr_d    = 16'd0;
            end else begin
              next_row = 1'b1;
            end
          end else begin
            word_d = word_q + 8'd1;
            bit_d  = 4'd0;
            sr_d   = rd_data;
          end
        end
      end
      GAP: begin
        bit_d = bit_q + 4'd1;
        sr_d  = 16'd0;
        if (bit_q == gap_q - 4'd1) next_row = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Row boundary: enable is only looked at here, so a row is never truncated.
    if (next_row) begin
      if (!enable) begin
        state_d = IDLE;
        row_d   = 6'd0;
        base_d  = 14'd0;
        bit_d   = 4'd0;
        word_d  = 8'd0;
        sr_d    = 16'd0;
      end else if (row_q == last_q) begin
        start_frame = 1'b1;
      end else begin
        state_d = HEADER;
        row_d   = row_q + 6'd1;
        base_d  = base_q + 14'(words_q);
        bit_d   = 4'd0;
        word_d  = 8'd0;
        sr_d    = {nx_q, ny_q, 2'b00, row_q + 6'd1};
      end
    end

    // Row 0 of every frame re-latches the configuration.
    if (start_frame) begin
      state_d = HEADER;
      nx_d    = cfg_nx;
      ny_d    = cfg_ny;
      gap_d   = cfg_gap;
      last_d  = cfg_last_row;
      words_d = w_new;
      row_d   = 6'd0;
      base_d  = 14'd0;
      bit_d   = 4'd0;
      word_d  = 8'd0;
      sr_d    = {cfg_nx, cfg_ny, 2'b00, 6'd0};
    end

    // Prefetch at bit 14 so data is on rd_data during bit 15 and loads without a bubble.
    rd_en_d   = (bit_d == 4'd14) &&
                ((state_d == HEADER) || ((state_d == PAYLOAD) && (word_d != wlast)));
    rd_addr_d = rd_addr_q;
    if (rd_en_d)
      rd_addr_d = (state_d == HEADER) ? base_d : base_d + 14'(word_d) + 14'd1;
    row_done_d   = (state_d == PAYLOAD) && (bit_d == 4'd15) && (word_d == wlast);
    frame_done_d = row_done_d && (row_d == last_q);
    busy_d       = (state_d != IDLE);
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_q        <= 4'd0;
      word_q       <= 8'd0;
      row_q        <= 6'd0;
      base_q       <= 14'd0;
      sr_q         <= 16'd0;
      nx_q         <= 4'd0;
      ny_q         <= 4'd0;
      gap_q        <= 4'd0;
      last_q       <= 6'd0;
      words_q      <= 9'd1;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 14'd0;
      busy_q       <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      word_q       <= word_d;
      row_q        <= row_d;
      base_q       <= base_d;
      sr_q         <= sr_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      gap_q        <= gap_d;
      last_q       <= last_d;
      words_q      <= words_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      busy_q       <= busy_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign i2s_data   = sr_q[15];
  assign busy       = busy_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_i2s_stream_scheduler.sv
// Bench for i2s_stream_scheduler: a per-cycle expected stream is built from a
// small row/frame model when each vector starts, then popped and compared at
// every negedge. Vector records also carry hand-computed event counts.
module tb_i2s_stream_scheduler;

  logic        i2s_clk = 1'b0;
  logic        rst, enable;
  logic [3:0]  cfg_nx, cfg_ny, cfg_gap;
  logic [5:0]  cfg_last_row;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [15:0] rd_data;
  logic        i2s_data, busy, row_done, frame_done;

  always #5 i2s_clk = ~i2s_clk;

  i2s_stream_scheduler dut (
    .i2s_clk(i2s_clk), .rst(rst), .enable(enable),
    .cfg_nx(cfg_nx), .cfg_ny(cfg_ny), .cfg_last_row(cfg_last_row), .cfg_gap(cfg_gap),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .i2s_data(i2s_data), .busy(busy), .row_done(row_done), .frame_done(frame_done)
  );

  function automatic logic [15:0] ram_val(input logic [13:0] a);
    return 16'hA5C3 ^ ({2'b00, a} * 16'h0B17);
  endfunction

  // Frame RAM: one-cycle read latency.
  always @(posedge i2s_clk) if (rd_en) rd_data <= ram_val(rd_addr);

  typedef struct packed {
    logic        d;
    logic        en;
    logic [13:0] addr;
    logic        busy;
    logic        rd;
    logic        fd;
  } exp_t;

  typedef struct {
    int nx, ny, last, gap, nrows, nx2;
    int exp_rd, exp_rows, exp_frames;
  } vec_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic en, input int addr,
                              input logic b, input logic rd, input logic fd);
    exp_t e;
    e.d = d; e.en = en; e.addr = en ? 14'(addr) : 14'd0; e.busy = b; e.rd = rd; e.fd = fd;
    return e;
  endfunction

  // Model: expected per-cycle outputs for nrows rows; enable drops at payload bit 5 of the last row.
  task automatic build_exp(input vec_t v, output int drop_j);
    int nx, ny, row, base, w, j;
    logic [15:0] hdr, wv;
    nx = v.nx; ny = v.ny; row = 0; base = 0; j = 0; drop_j = 0;
    for (int r = 0; r < v.nrows; r++) begin
      if (r == v.nrows - 1) drop_j = j + 22;
      w   = (nx + 1) * (ny + 1);
      hdr = {4'(nx), 4'(ny), 2'b00, 6'(row)};
      for (int i = 0; i < 16; i++) begin
        q.push_back(mk(hdr[15-i], i == 14, base, 1'b1, 1'b0, 1'b0)); j++;
      end
      for (int k = 0; k < w; k++) begin
        wv = ram_val(14'(base + k));
        for (int i = 0; i < 16; i++) begin
          q.push_back(mk(wv[15-i], (i == 14) && (k < w - 1), base + k + 1, 1'b1,
                         (k == w - 1) && (i == 15), (k == w - 1) && (i == 15) && (row == v.last)));
          j++;
        end
      end
      for (int g = 0; g < v.gap; g++) begin
        q.push_back(mk(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0)); j++;
      end
      if (row == v.last) begin
        row = 0; base = 0; nx = v.nx2;
      end else begin
        row++; base += w;
      end
    end
    for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  // Launch a vector at a negedge and score every cycle until the queue drains.
  task automatic run_vec(input int id, input vec_t v);
    int drop_j, j, n_rd, n_row, n_fr;
    exp_t e, g;
    build_exp(v, drop_j);
    cfg_nx = 4'(v.nx); cfg_ny = 4'(v.ny); cfg_last_row = 6'(v.last); cfg_gap = 4'(v.gap);
    enable = 1'b1;
    j = 0; n_rd = 0; n_row = 0; n_fr = 0;
    while (q.size() > 0) begin
      @(negedge i2s_clk);
      j++;
      e = q.pop_front();
      g = mk(i2s_data, rd_en, int'(rd_addr), busy, row_done, frame_done);
      if (!e.en) g.addr = 14'd0;
      chk($sformatf("v%0d_cyc%0d {d,en,addr,busy,rd,fd}", id, j), 32'(g), 32'(e));
      n_rd  += int'(rd_en);
      n_row += int'(row_done);
      n_fr  += int'(frame_done);
      if (j == 2) cfg_nx = 4'(v.nx2);
      if (j == drop_j) enable = 1'b0;
    end
    chk($sformatf("v%0d_rd_en_count", id), n_rd, v.exp_rd);
    chk($sformatf("v%0d_row_done_count", id), n_row, v.exp_rows);
    chk($sformatf("v%0d_frame_done_count", id), n_fr, v.exp_frames);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i2s_data"}, 32'(i2s_data), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_row_done"}, 32'(row_done), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int act;
    //            nx ny last gap rows nx2  rd rows frames
    vecs[0] = '{0, 0, 0, 0, 1, 0,   1, 1, 1};   // single word row, RAM[0]=A5C3
    vecs[1] = '{1, 1, 2, 0, 4, 1,  16, 4, 1};   // 3-row frame plus wrap to row 0
    vecs[2] = '{1, 0, 1, 3, 3, 1,   6, 3, 1};   // 3-bit gap between rows
    vecs[3] = '{0, 1, 3, 0, 2, 0,   4, 2, 0};   // stop during row 1
    vecs[4] = '{0, 1, 3, 0, 1, 0,   2, 1, 0};   // restart begins at row 0
    vecs[5] = '{0, 0, 1, 1, 3, 2,   5, 3, 1};   // nx change applies at next frame
    vecs[6] = '{3, 2, 1, 2, 2, 3,  24, 2, 1};   // W=12

    rst = 1'b1; enable = 1'b0;
    cfg_nx = 4'd0; cfg_ny = 4'd0; cfg_last_row = 6'd0; cfg_gap = 4'd0;
    repeat (3) @(negedge i2s_clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge i2s_clk);
    chk("idle_after_reset_busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of payload word 1 with enable still high.
    cfg_nx = 4'd1; cfg_ny = 4'd1; cfg_last_row = 6'd2; cfg_gap = 4'd0;
    enable = 1'b1;
    repeat (40) @(negedge i2s_clk);
    chk("midrun_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    @(negedge i2s_clk);
    chk_all_zero("midrun_rst");
    rst = 1'b0; enable = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge i2s_clk);
      act += int'(rd_en) + int'(busy) + int'(i2s_data);
    end
    chk("post_rst_idle_activity", act, 0);

    // Restart after reset begins cleanly at row 0, address 0.
    run_vec(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_stream_scheduler.md
I2S_STREAM_SCHEDULER -- requirements
Module: i2s_stream_scheduler

Interface
REQ-001 SHALL have one clock and one reset: i2s_clk (in, 1), bit clock; all logic on posedge; board forwards it to the panel receivers.
REQ-002 SHALL have rst (in, 1): synchronous, active-high reset.
REQ-003 SHALL have enable (in, 1): level; 1 = stream rows continuously, 0 = stop at the next row boundary.
REQ-004 SHALL have cfg_nx (in, 4): modules in X minus one.
REQ-005 SHALL have cfg_ny (in, 4): modules in Y minus one.
REQ-006 SHALL have cfg_last_row (in, 6): number of scan rows minus one.
REQ-007 SHALL have cfg_gap (in, 4): idle bit-times inserted after each row.
REQ-008 SHALL have rd_en (out, 1) and rd_addr (out, 14): frame-RAM word read request and address.
REQ-009 SHALL have rd_data (in, 16): frame-RAM word, valid exactly one cycle after rd_en.
REQ-010 SHALL have i2s_data (out, 1): serial stream, MSB first.
REQ-011 SHALL have busy (out, 1): high in any non-IDLE state.
REQ-012 SHALL have row_done (out, 1) and frame_done (out, 1): single-cycle pulses.

Function
REQ-013 SHALL implement FSM states IDLE, HEADER, PAYLOAD, GAP.
REQ-014 IDLE -> HEADER SHALL occur when enable=1; cfg_nx, cfg_ny, cfg_last_row and cfg_gap are latched on that cycle and on every transition into HEADER for row 0 only; mid-frame cfg changes SHALL be ignored.
REQ-015 HEADER SHALL last exactly 16 cycles and emit header word {nx[3:0], ny[3:0], 2'b00, row[5:0]} MSB first, one bit per cycle.
REQ-016 PAYLOAD SHALL last exactly W*16 cycles, where W = (nx+1)*(ny+1) is words per row (1..256).
REQ-017 Payload word k of row r SHALL come from rd_addr = r*W + k; the base SHALL be accumulated per row (base += W), not multiplied; the 14-bit width covers 64*256 words.
REQ-018 Each payload word SHALL be emitted MSB first.
REQ-019 Reads SHALL be prefetched with no bubbles: rd_en pulses at header bit 14 for word 0 and at bit 14 of word k for word k+1 (never past word W-1).
REQ-020 rd_data SHALL be loaded into the shift register on the cycle after the read, so i2s_data is continuous across header/payload and word boundaries.
REQ-021 rd_en SHALL be high for at most one cycle per word.
REQ-022 After the last payload bit the FSM SHALL go to GAP for cfg_gap cycles with i2s_data=0; cfg_gap=0 SHALL skip GAP and go straight to the next state.
REQ-023 row_done SHALL pulse on the last payload bit cycle.
REQ-024 Next state after a row SHALL be: HEADER for row+1 if row<last_row; else HEADER for row 0 with frame_done pulsed together with row_done and base reset to 0.
REQ-025 If enable=0 at the row boundary, the FSM SHALL instead go to IDLE after GAP; deasserting enable mid-row SHALL NOT truncate the row.
REQ-026 A stop SHALL reset row and base to 0, so the next start begins at row 0.
REQ-027 In IDLE, i2s_data, rd_en, busy, row_done and frame_done SHALL all be 0.

Reset
REQ-028 rst=1 SHALL force, on the next posedge: state IDLE, row=0, base=0, bit/word counters=0, shift register=0, and all outputs 0 (rd_addr=0).
REQ-029 rst SHALL take priority over every event, including mid-row, mid-read and enable=1.
REQ-030 After rst falls, the block SHALL stay in IDLE until it samples enable=1.

Verification
REQ-031 nx=0, ny=0, last_row=0, gap=0, RAM[0]=16'hA5C3, enable pulsed for one row -> i2s_data = 16'h0000 header then A5C3 bits; rd_en once, rd_addr=0; row_done and frame_done on cycle 32; then IDLE.
REQ-032 nx=1, ny=1, last_row=2, enable held -> rows 0,1,2 read addresses 0-3, 4-7, 8-11; header row field 0,1,2; frame_done after row 2; next header row=0 with address 0, and no gap cycles between rows.
REQ-033 gap=3 -> exactly 3 zero bits between the last payload bit and the next header MSB; busy stays 1 throughout.
REQ-034 enable dropped at payload bit 5 of row 1 -> row 1 completes in full, then IDLE; re-enable -> header row=0, rd_addr=0.
REQ-035 rst asserted mid-payload -> next cycle all outputs 0 and state IDLE; no further rd_en until enable=1.
REQ-036 cfg_nx changed mid-frame -> W for the current frame unchanged; the new value is applied from the next row-0 header.
